// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of an N-input function held as a minterm mask,
// streaming one row per handshake and counting minterms. Optional: TRUTH_TABLE_EQUIV_CHECK_EN.
module truth_table_sweeper #(
   parameter int N = 3,
   localparam int ROWS = 2**N
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [ROWS-1:0] func,
`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
   input  logic [ROWS-1:0] func_b,
   output logic [N:0]      mismatch_count,
   output logic            equiv,
`endif
   output logic            busy,
   output logic            row_valid,
   input  logic            row_ready,
   output logic [N-1:0]    row_in,
   output logic            row_out,
   output logic [N:0]      minterm_count,
   output logic            done,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [ROWS-1:0] func_q;
   logic [N-1:0]    cnt_q;
   logic            accept;
   logic            last_row;

   // Handshake: a row transfers on any cycle with row_valid & row_ready; while
   // row_ready is low the row stays presented unchanged and row_valid stays high.
   assign accept    = (state_q == S_SWEEP) && row_ready;
   assign last_row  = (cnt_q == N'(ROWS - 1));
   assign row_in    = cnt_q;
   assign row_out   = row_valid & func_q[cnt_q];
   assign dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SWEEP;
         S_SWEEP: if (accept && last_row) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
   logic [ROWS-1:0] func_b_q;
   logic            row_differs;

   assign row_differs = func_q[cnt_q] ^ func_b_q[cnt_q];

   // equiv is resolved on the terminal accept so it already covers the last row in DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         func_b_q       <= '0;
         mismatch_count <= '0;
         equiv          <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         func_b_q       <= func_b;
         mismatch_count <= '0;
         equiv          <= 1'b0;
      end else if (accept) begin
         mismatch_count <= mismatch_count + (N+1)'(row_differs);
         if (last_row)
            equiv <= (mismatch_count == '0) && !row_differs;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         func_q        <= '0;
         cnt_q         <= '0;
         minterm_count <= '0;
         busy          <= 1'b0;
         row_valid     <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy      <= (state_d == S_SWEEP);
         row_valid <= (state_d == S_SWEEP);
         done      <= (state_d == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  func_q        <= func;
                  cnt_q         <= '0;
                  minterm_count <= '0;
               end
            end
            S_SWEEP: begin
               if (accept) begin
                  minterm_count <= minterm_count + (N+1)'(row_out);
                  if (!last_row) cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (N=3): table-driven and random sweeps against a
// mask-level model, plus reset and start-collision sequences.
module tb_truth_table_sweeper;
   localparam int N    = 3;
   localparam int ROWS = 8;

   logic            clk = 1'b0;
   logic            reset, start, row_ready;
   logic [ROWS-1:0] func;
   logic            busy, row_valid, row_out, done;
   logic [N-1:0]    row_in;
   logic [N:0]      minterm_count;
   logic [1:0]      dbg_state;
`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
   logic [ROWS-1:0] func_b;
   logic [N:0]      mismatch_count;
   logic            equiv;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [N:0] exp_q[$];   // {row_in, row_out} in expected stream order

   always #5 clk = ~clk;

   truth_table_sweeper #(.N(N)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .func          (func),
`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
      .func_b        (func_b),
      .mismatch_count(mismatch_count),
      .equiv         (equiv),
`endif
      .busy          (busy),
      .row_valid     (row_valid),
      .row_ready     (row_ready),
      .row_in        (row_in),
      .row_out       (row_out),
      .minterm_count (minterm_count),
      .done          (done),
      .dbg_state     (dbg_state)
   );

   typedef struct {
      logic [ROWS-1:0] f;
      logic [ROWS-1:0] fb;
      int              mode;      // 0: always ready, 1: toggle, 2: random
      int              exp_mint;
      int              exp_mism;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int popcount(input logic [ROWS-1:0] m);
      int c = 0;
      for (int i = 0; i < ROWS; i++) c += int'(m[i]);
      return c;
   endfunction

   function automatic int diffcount(input logic [ROWS-1:0] a, input logic [ROWS-1:0] b);
      return popcount(a ^ b);
   endfunction

   task automatic run_sweep(input logic [ROWS-1:0] f, input logic [ROWS-1:0] fb,
                            input int mode, input bit disturb,
                            input int exp_mint, input int exp_mism);
      int  cyc      = 0;
      int  accepted = 0;
      bit  seen_done = 0;
      bit  r;
      logic [N:0] e;
      exp_q.delete();
      for (int i = 0; i < ROWS; i++) exp_q.push_back({N'(i), f[i]});
      @(negedge clk);
      func  = f;
`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
      func_b = fb;
`endif
      start = 1'b1;
      row_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("first_row_latency", int'(row_valid), 1);
      while (cyc < 100) begin
         if (done) begin
            seen_done = 1;
            check("done_busy_low", int'(busy), 0);
            check("done_valid_low", int'(row_valid), 0);
            break;
         end
         if (!row_valid || exp_q.size() == 0) begin
            check("valid_during_sweep", int'(row_valid), 1);
            break;
         end
         e = exp_q[0];
         if (row_in != e[N:1] || row_out != e[0]) begin
            check("row_in", int'(row_in), int'(e[N:1]));
            check("row_out", int'(row_out), int'(e[0]));
         end
         start = disturb && (cyc == 3);
         if (disturb && cyc == 3) func = '1;
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            default: r = ($urandom_range(0, 2) != 0);
         endcase
         row_ready = r;
         if (r) begin
            void'(exp_q.pop_front());
            accepted++;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      row_ready = 1'b0;
      check("done_seen", int'(seen_done), 1);
      check("rows_accepted", accepted, ROWS);
      check("minterm_count_done", int'(minterm_count), exp_mint);
`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
      check("mismatch_count_done", int'(mismatch_count), exp_mism);
`endif
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("minterm_count_held", int'(minterm_count), exp_mint);
      check("idle_busy_low", int'(busy), 0);
`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
      check("equiv", int'(equiv), (exp_mism == 0) ? 1 : 0);
`endif
   endtask

   initial begin
      logic [ROWS-1:0] rf, rfb;
      bit   hit, stray;
      vecs[0] = '{8'hB0, 8'hB0, 0, 3, 0};
      vecs[1] = '{8'h96, 8'h97, 1, 4, 1};
      vecs[2] = '{8'h66, 8'h66, 1, 4, 0};
      vecs[3] = '{8'hFF, 8'h00, 2, 8, 8};
      vecs[4] = '{8'h00, 8'h00, 2, 0, 0};
      vecs[5] = '{8'h81, 8'h01, 0, 2, 1};

      reset = 1'b1; start = 1'b0; row_ready = 1'b0; func = '0;
`ifdef TRUTH_TABLE_EQUIV_CHECK_EN
      func_b = '0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", int'(busy), 0);
      check("reset_valid", int'(row_valid), 0);
      check("reset_row_in", int'(row_in), 0);
      check("reset_row_out", int'(row_out), 0);
      check("reset_minterm", int'(minterm_count), 0);
      check("reset_done", int'(done), 0);

      for (int v = 0; v < 6; v++)
         run_sweep(vecs[v].f, vecs[v].fb, vecs[v].mode, 1'b0, vecs[v].exp_mint, vecs[v].exp_mism);

      // mid-sweep func change and start pulse must not disturb the sweep
      run_sweep(8'hB0, 8'hB0, 0, 1'b1, 3, 0);
      run_sweep(8'hFF, 8'hFF, 0, 1'b0, 8, 0);

      // reset while row 3 is presented
      @(negedge clk);
      func = 8'hB0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; row_ready = 1'b1;
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
         if (row_valid && row_in == 3'd3) hit = 1;
         else @(negedge clk);
      end
      check("reached_row3", int'(hit), 1);
      reset = 1'b1; row_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", int'(busy), 0);
      check("midreset_valid", int'(row_valid), 0);
      check("midreset_row_in", int'(row_in), 0);
      check("midreset_minterm", int'(minterm_count), 0);
      stray = 0;
      for (int c = 0; c < 4; c++) begin
         if (done || busy) stray = 1;
         @(negedge clk);
      end
      check("no_done_after_reset", int'(stray), 0);
      run_sweep(8'hB0, 8'hB0, 0, 1'b0, 3, 0);

      // start and reset together: reset wins
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("collide_busy", int'(busy), 0);
      check("collide_valid", int'(row_valid), 0);
      @(negedge clk);
      check("collide_stay_idle", int'(busy), 0);

      for (int k = 0; k < 4; k++) begin
         rf  = ROWS'($urandom);
         rfb = ($urandom_range(0, 1) == 0) ? rf : ROWS'($urandom);
         run_sweep(rf, rfb, 2, 1'b0, popcount(rf), diffcount(rf, rfb));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
